ppu_reg_snoop: RTL

- Passive snooper on the PPU B-bus (PAWR/PADDRESS/DATA), upstream of the RGB scaler/OSD/DAC stage on the test board.
- Decodes the PPU registers that the video path depends on: INIDISP $2100, BGMODE $2105, M7SEL $211A, SETINI $2133.
- Publishes clean, MCLK-synchronous state: brightness, forced blank, mode flags, Mode 7 over-patch request, DAC clock select.
- Also provides a per-frame write-activity counter for debug LEDs.

---
 rtl/ppu_reg_pkg.sv | 34 +++
 rtl/bus_write_capture.sv | 39 +++
 rtl/ppu_reg_snoop.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ppu_reg_pkg.sv
// Shared constants for the PPU B-bus register snooper: watched addresses,
// reset values and BG mode groupings.
package ppu_reg_pkg;

   localparam logic [7:0] ADDR_INIDISP = 8'h00;
   localparam logic [7:0] ADDR_BGMODE  = 8'h05;
   localparam logic [7:0] ADDR_M7SEL   = 8'h1A;
   localparam logic [7:0] ADDR_SETINI  = 8'h33;

   localparam logic [3:0] BRIGHT_RST = 4'hF;

   localparam logic [2:0] BGMODE_5 = 3'd5;
   localparam logic [2:0] BGMODE_6 = 3'd6;
   localparam logic [2:0] BGMODE_7 = 3'd7;

   typedef enum logic [1:0] {
      GRP_01234 = 2'd0,
      GRP_56    = 2'd1,
      GRP_7     = 2'd2
   } mode_grp_e;

   function automatic mode_grp_e mode_group(input logic [2:0] m);
      if (m == BGMODE_7)                     return GRP_7;
      else if (m == BGMODE_5 || m == BGMODE_6) return GRP_56;
      else                                   return GRP_01234;
   endfunction

   // Registers that count toward the per-frame write-activity counter.
   function automatic logic is_watched(input logic [7:0] a);
      return (a == ADDR_INIDISP) || (a == ADDR_BGMODE) ||
             (a == ADDR_M7SEL)   || (a == ADDR_SETINI);
   endfunction

endpackage

// File: rtl/bus_write_capture.sv
// PAWR synchronizer, address/data hold register and commit-edge detect.
// The preset-to-1 synchronizer keeps a reset release from faking a write.
module bus_write_capture #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pawr,
   input  logic [7:0] addr_in,
   input  logic [7:0] data_in,
   output logic       commit,
   output logic [7:0] addr,
   output logic [7:0] data
);

   logic [SYNC_STAGES-1:0] pawr_sync;
   logic                   pawr_q;
   logic                   pawr_s;

   assign pawr_s = pawr_sync[SYNC_STAGES-1];
   assign commit = pawr_s & ~pawr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pawr_sync <= '1;
         pawr_q    <= 1'b1;
         addr      <= '0;
         data      <= '0;
      end else begin
         pawr_sync <= {pawr_sync[SYNC_STAGES-2:0], pawr};
         pawr_q    <= pawr_s;
         if (!pawr_s) begin
            addr <= addr_in;
            data <= data_in;
         end
      end
   end

endmodule

// File: rtl/ppu_reg_snoop.sv
// Passive PPU B-bus snooper: decodes INIDISP/BGMODE/M7SEL/SETINI into clean
// MCLK-domain video state, DAC clock select and a per-frame write counter.
module ppu_reg_snoop
   import ppu_reg_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int CNT_W           = 8,
   parameter bit HIRES_AT_HBLANK = 1'b1
) (
   input  logic             MCLK,
   input  logic             RESETI,
   input  logic             PAWR,
   input  logic [7:0]       PADDRESS,
   input  logic [7:0]       DATA,
   input  logic             HBLANK,
   input  logic             VBLANK,
   output logic [3:0]       BRIGHTNESS,
   output logic             FBLANK,
   output logic [2:0]       BGMODE,
   output logic             MODE01234,
   output logic             MODE56,
   output logic             MODE7,
   output logic             SCREEN_OVER,
   output logic             OVER,
   output logic             PSEUDOHIRES,
   output logic             INTERLACE,
   output logic             HIRES_SEL,
   output logic             WR_STROBE,
   output logic [7:0]       WR_ADDR,
   output logic [7:0]       WR_DATA,
   output logic [CNT_W-1:0] FRAME_WRITES
);

   logic       commit;
   logic [7:0] cap_addr, cap_data;

   bus_write_capture #(.SYNC_STAGES(SYNC_STAGES)) u_cap (
      .clk     (MCLK),
      .rst     (RESETI),
      .pawr    (PAWR),
      .addr_in (PADDRESS),
      .data_in (DATA),
      .commit  (commit),
      .addr    (cap_addr),
      .data    (cap_data)
   );

   logic [SYNC_STAGES-1:0] hb_sync, vb_sync;
   logic                   hb_q, vb_q;
   logic                   hb_rise, vb_rise;

   assign hb_rise = hb_sync[SYNC_STAGES-1] & ~hb_q;
   assign vb_rise = vb_sync[SYNC_STAGES-1] & ~vb_q;

   always_ff @(posedge MCLK or posedge RESETI) begin
      if (RESETI) begin
         hb_sync <= '0;
         vb_sync <= '0;
         hb_q    <= 1'b0;
         vb_q    <= 1'b0;
      end else begin
         hb_sync <= {hb_sync[SYNC_STAGES-2:0], HBLANK};
         vb_sync <= {vb_sync[SYNC_STAGES-2:0], VBLANK};
         hb_q    <= hb_sync[SYNC_STAGES-1];
         vb_q    <= vb_sync[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge MCLK or posedge RESETI) begin
      if (RESETI) begin
         BRIGHTNESS  <= BRIGHT_RST;
         FBLANK      <= 1'b0;
         BGMODE      <= '0;
         MODE01234   <= 1'b1;
         MODE56      <= 1'b0;
         MODE7       <= 1'b0;
         SCREEN_OVER <= 1'b0;
         PSEUDOHIRES <= 1'b0;
         INTERLACE   <= 1'b0;
         WR_STROBE   <= 1'b0;
         WR_ADDR     <= '0;
         WR_DATA     <= '0;
      end else begin
         WR_STROBE <= commit;
         if (commit) begin
            WR_ADDR <= cap_addr;
            WR_DATA <= cap_data;
            case (cap_addr)
               ADDR_INIDISP: begin
                  BRIGHTNESS <= cap_data[3:0];
                  FBLANK     <= cap_data[7];
               end
               ADDR_BGMODE: begin
                  BGMODE    <= cap_data[2:0];
                  MODE01234 <= (mode_group(cap_data[2:0]) == GRP_01234);
                  MODE56    <= (mode_group(cap_data[2:0]) == GRP_56);
                  MODE7     <= (mode_group(cap_data[2:0]) == GRP_7);
               end
               ADDR_M7SEL:  SCREEN_OVER <= (cap_data[7:6] == 2'b10);
               ADDR_SETINI: begin
                  PSEUDOHIRES <= cap_data[3];
                  INTERLACE   <= cap_data[0];
               end
               default: ;
            endcase
         end
      end
   end

   logic hires_req;
   assign OVER      = MODE7 & SCREEN_OVER;
   assign hires_req = MODE56 | (PSEUDOHIRES & MODE01234);

   // Deferring to HBLANK keeps the DAC clock from switching mid-line.
   generate
      if (HIRES_AT_HBLANK) begin : g_hires_hb
         always_ff @(posedge MCLK or posedge RESETI) begin
            if (RESETI)       HIRES_SEL <= 1'b0;
            else if (hb_rise) HIRES_SEL <= hires_req;
         end
      end else begin : g_hires_imm
         assign HIRES_SEL = hires_req;
      end
   endgenerate

   logic [CNT_W-1:0] cnt;
   logic             count_wr;
   assign count_wr = commit & is_watched(cap_addr);

   // A commit coinciding with the VBLANK rise belongs to the new frame.
   always_ff @(posedge MCLK or posedge RESETI) begin
      if (RESETI) begin
         cnt          <= '0;
         FRAME_WRITES <= '0;
      end else if (vb_rise) begin
         FRAME_WRITES <= cnt;
         cnt          <= count_wr ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
      end else if (count_wr && cnt != '1) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule
